scope_capture_buffer: RTL and testbench

Oscilloscope acquisition stage directly downstream of the variable-frequency clock generator. It uses the generator's clk_out, fed in as sample_clk, as the sample-rate tick. On each rising edge of sample_clk it stores one ADC sample into a circular buffer. It runs level/edge trigger detection with programmable pre-trigger depth, then freezes a trigger-aligned record for the display/readout logic.

---
 rtl/scope_capture_buffer.sv | 153 +++++++++++++++
 tb/tb_scope_capture_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_buffer.sv
// Trigger-aligned acquisition buffer for the scope front end.
// Samples data_in on each synchronized sample_clk edge into a circular record.
module scope_capture_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PREFILL   = 3'd1;
  localparam logic [2:0] S_WAIT_TRIG = 3'd2;
  localparam logic [2:0] S_POST      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]        state;
  logic [2:0]        next_state;

  logic              s1, s2, s3;
  logic              strobe_c;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] pretrig_l;
  logic [DATA_W-1:0] trig_level_l;
  logic              trig_rising_l;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  logic              arm_accept_c;
  logic              capture_c;
  logic              trig_cond_c;
  logic              trig_hit_c;
  logic [ADDR_W-1:0] post_init_c;
  logic [ADDR_W-1:0] rd_idx_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Two-flop synchronizer plus edge-detect flop for the sample tick
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sample_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe_c     = s2 & ~s3;
  assign arm_accept_c = arm & ((state == S_IDLE) | (state == S_DONE));
  assign capture_c    = strobe_c & ((state == S_PREFILL) | (state == S_WAIT_TRIG) |
                                    (state == S_POST));
  assign trig_cond_c  = trig_rising_l ? ((prev < trig_level_l) && (data_in >= trig_level_l))
                                      : ((prev > trig_level_l) && (data_in <= trig_level_l));
  assign trig_hit_c   = (state == S_WAIT_TRIG) & strobe_c & prev_valid & trig_cond_c;
  assign post_init_c  = ADDR_W'(DEPTH - 1) - pretrig_l;
  // Oldest record sample lies pretrig_l slots behind the trigger; natural wrap
  assign rd_idx_c     = trig_addr - pretrig_l + rd_addr;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm) next_state = S_PREFILL;
      end
      S_PREFILL: begin
        if (fill_cnt == pretrig_l) next_state = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        if (trig_hit_c) next_state = (post_init_c == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (strobe_c && (post_cnt == ADDR_W'(1))) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      trig_addr     <= '0;
      pretrig_l     <= '0;
      trig_level_l  <= '0;
      trig_rising_l <= 1'b0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      triggered     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_data       <= '0;
    end else begin
      busy    <= (next_state == S_PREFILL) | (next_state == S_WAIT_TRIG) |
                 (next_state == S_POST);
      done    <= (next_state == S_DONE);
      rd_data <= mem[rd_idx_c];
      if (arm_accept_c) begin
        wr_ptr        <= '0;
        fill_cnt      <= '0;
        prev_valid    <= 1'b0;
        triggered     <= 1'b0;
        pretrig_l     <= pretrig;
        trig_level_l  <= trig_level;
        trig_rising_l <= trig_rising;
      end else begin
        if (capture_c) begin
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          prev       <= data_in;
          prev_valid <= 1'b1;
        end
        if ((state == S_PREFILL) && strobe_c) fill_cnt <= fill_cnt + ADDR_W'(1);
        if (trig_hit_c) begin
          trig_addr <= wr_ptr;
          triggered <= 1'b1;
          post_cnt  <= post_init_c;
        end else if ((state == S_POST) && strobe_c) begin
          post_cnt <= post_cnt - ADDR_W'(1);
        end
      end
    end
  end

  // Sample storage; intentionally not reset
  always_ff @(posedge clk_in) begin
    if (capture_c) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer at DEPTH=16, DATA_W=8.
// Expected record contents are queued as each readout address is driven.
module tb_scope_capture_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              sample_clk;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic [ADDR_W-1:0] pretrig;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic              triggered;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_rec [DEPTH];

  scope_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sample_clk  (sample_clk),
    .arm         (arm),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .pretrig     (pretrig),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .triggered   (triggered),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // sample_clk high for 5 clk_in cycles, low for 3: one rising edge per call
  task automatic sample(input logic [DATA_W-1:0] d);
    data_in    = d;
    sample_clk = 1'b1;
    repeat (5) tick();
    sample_clk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_arm(input logic [DATA_W-1:0] lvl, input logic rise,
                        input logic [ADDR_W-1:0] pre);
    trig_level  = lvl;
    trig_rising = rise;
    pretrig     = pre;
    arm         = 1'b1;
    tick();
    arm         = 1'b0;
  endtask

  task automatic read_record(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_addr = ADDR_W'(i);
      exp_q.push_back(exp_rec[i]);
      tick();
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  function automatic logic [DATA_W-1:0] cross_val(input int k);
    if (k >= 20)     return DATA_W'(100 + k);
    else if (k == 3) return DATA_W'(200);
    else             return DATA_W'(k);
  endfunction

  initial begin
    rst         = 1'b1;
    sample_clk  = 1'b0;
    arm         = 1'b0;
    trig_level  = '0;
    trig_rising = 1'b1;
    pretrig     = '0;
    data_in     = '0;
    rd_addr     = '0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_trig", 32'(triggered), 0);
    check("reset_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 0);

    // Rising ramp, pretrig 4; a re-arm while busy with other settings is ignored
    do_arm(8'd100, 1'b1, 4'd4);
    check("ramp_busy_after_arm", 32'(busy), 1);
    for (int k = 0; k <= 111; k++) begin
      if (k == 50) do_arm(8'd200, 1'b0, 4'd2);
      sample(DATA_W'(k));
      if (k == 50)  check("ramp_rearm_busy", 32'(busy), 1);
      if (k == 99)  check("ramp_trig_before", 32'(triggered), 0);
      if (k == 100) check("ramp_trig_at", 32'(triggered), 1);
      if (k == 110) check("ramp_done_before", 32'(done), 0);
    end
    check("ramp_done", 32'(done), 1);
    check("ramp_busy_done", 32'(busy), 0);
    sample(8'd222);
    for (int i = 0; i < int'(DEPTH); i++) exp_rec[i] = DATA_W'(96 + i);
    read_record("ramp");
    rd_addr = 4'd4;
    exp_q.push_back(8'd100);
    tick();
    check("ramp_trigger_sample", 32'(rd_data), 32'(exp_q.pop_front()));

    // Falling edge, pretrig 0
    do_arm(8'd150, 1'b0, 4'd0);
    for (int k = 0; k <= 25; k++) begin
      sample(DATA_W'(250 - 10 * k));
      if (k == 9)  check("fall_trig_before", 32'(triggered), 0);
      if (k == 10) check("fall_trig_at", 32'(triggered), 1);
    end
    check("fall_done", 32'(done), 1);
    for (int i = 0; i < int'(DEPTH); i++) exp_rec[i] = DATA_W'(150 - 10 * i);
    read_record("fall");

    // Level crossing during prefill must not trigger
    do_arm(8'd50, 1'b1, 4'd8);
    for (int k = 1; k <= 27; k++) begin
      sample(cross_val(k));
      if (k == 3)  check("cross_prefill_no_trig", 32'(triggered), 0);
      if (k == 19) check("cross_trig_before", 32'(triggered), 0);
      if (k == 20) check("cross_trig_at", 32'(triggered), 1);
      if (k == 26) check("cross_done_before", 32'(done), 0);
    end
    check("cross_done", 32'(done), 1);
    for (int i = 0; i < int'(DEPTH); i++) exp_rec[i] = cross_val(12 + i);
    read_record("cross");

    // pretrig = DEPTH-1: record completes on the trigger sample itself
    do_arm(8'd100, 1'b1, 4'd15);
    for (int k = 0; k <= 100; k++) begin
      sample(DATA_W'(k));
      if (k == 99) check("full_pre_done_before", 32'(done), 0);
    end
    check("full_pre_done", 32'(done), 1);
    check("full_pre_trig", 32'(triggered), 1);
    sample(8'd201);
    for (int i = 0; i < int'(DEPTH); i++) exp_rec[i] = DATA_W'(85 + i);
    read_record("full_pre");

    // Asynchronous reset during POST
    do_arm(8'd100, 1'b1, 4'd4);
    for (int k = 0; k <= 103; k++) sample(DATA_W'(k));
    check("abort_busy_before", 32'(busy), 1);
    check("abort_trig_before", 32'(triggered), 1);
    rd_addr = 4'd4;
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_trig", 32'(triggered), 0);
    check("abort_rd_data", 32'(rd_data), 0);
    tick();
    rst = 1'b0;
    sample(8'd104);
    check("abort_idle_busy", 32'(busy), 0);
    check("abort_idle_done", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
